// File: rtl/vend_pkg.sv
// Shared vending constants: coin values, dispenser FSM states, coin-select one-hot.
package vend_pkg;

    localparam int unsigned DOLLAR_CENTS  = 100;
    localparam int unsigned QUARTER_CENTS = 25;
    localparam int unsigned DIME_CENTS    = 10;

    // Width of each per-denomination inventory counter.
    localparam int unsigned INV_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REQ,
        ST_DONE
    } disp_state_e;

    // One-hot coin select, bit order {dollar, quarter, dime}.
    typedef logic [2:0] coin_sel_t;

    localparam coin_sel_t SEL_NONE    = 3'b000;
    localparam coin_sel_t SEL_DOLLAR  = 3'b100;
    localparam coin_sel_t SEL_QUARTER = 3'b010;
    localparam coin_sel_t SEL_DIME    = 3'b001;

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination stock counters with empty flags. Bit order {dollar, quarter, dime}.
// Refill has priority over a decrement in the same cycle; counters never wrap below 0.
module coin_inventory
    import vend_pkg::*;
#(
    parameter int unsigned INV_INIT = 20
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      refill_i,
    input  coin_sel_t dec_i,
    output coin_sel_t avail_o,
    output logic [2:0] empty_o
);

    logic [2:0][INV_W-1:0] cnt_q, cnt_d;

    // Next count: reload on refill, else decrement the acked denomination.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (refill_i) begin
                cnt_d[i] = INV_W'(INV_INIT);
            end else if (dec_i[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - INV_W'(1);
            end
        end
    end

    // Counter registers, loaded with the initial stock on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {3{INV_W'(INV_INIT)}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Stock flags derived from the current counts.
    always_comb begin
        avail_o = SEL_NONE;
        for (int i = 0; i < 3; i++) begin
            avail_o[i] = (cnt_q[i] != '0);
        end
        empty_o = ~avail_o;
    end

endmodule

// File: rtl/coin_change_dispenser.sv
// Greedy coin change dispenser: dollar > quarter > dime, one coin per ack handshake.
// Optional macro COIN_INVENTORY_EN adds finite per-denomination stock with refill;
// without it supply is unlimited and inv_empty reads 0.
module coin_change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned DOLLAR_VAL  = DOLLAR_CENTS,
    parameter int unsigned QUARTER_VAL = QUARTER_CENTS,
    parameter int unsigned DIME_VAL    = DIME_CENTS,
    parameter int unsigned INV_INIT    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] change_in,
    input  logic        abort,
    input  logic        coin_ack,
    input  logic        refill,
    output logic        req_dollar,
    output logic        req_quarter,
    output logic        req_dime,
    output logic        busy,
    output logic        done,
    output logic [15:0] leftover,
    output logic [7:0]  coins_out,
    output logic [2:0]  inv_empty
);

    disp_state_e state_q, state_d;
    coin_sel_t   sel_q, sel_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] leftover_q, leftover_d;
    logic [7:0]  coins_q, coins_d;
    logic        done_q, done_d;
    logic        busy_q;
    logic [15:0] coin_val;
    coin_sel_t   avail;
    logic        acked;

    // Only an ack while a request is outstanding counts as an ejected coin.
    assign acked = (state_q == ST_REQ) && coin_ack;

`ifdef COIN_INVENTORY_EN
    coin_sel_t dec;
    assign dec = acked ? sel_q : SEL_NONE;

    coin_inventory #(
        .INV_INIT (INV_INIT)
    ) u_inv (
        .clk      (clk),
        .rst      (rst),
        .refill_i (refill),
        .dec_i    (dec),
        .avail_o  (avail),
        .empty_o  (inv_empty)
    );
`else
    logic        unused_refill;
    logic [31:0] unused_inv_init;
    assign unused_refill   = refill;
    assign unused_inv_init = INV_INIT;
    assign avail           = 3'b111;
    assign inv_empty       = 3'b000;
`endif

    // Value of the coin currently being requested.
    always_comb begin
        coin_val = '0;
        if (sel_q[2])      coin_val = 16'(DOLLAR_VAL);
        else if (sel_q[1]) coin_val = 16'(QUARTER_VAL);
        else if (sel_q[0]) coin_val = 16'(DIME_VAL);
    end

    // Next state, coin choice and payout bookkeeping.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rem_d      = rem_q;
        coins_d    = coins_q;
        leftover_d = leftover_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d   = change_in;
                    coins_d = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if ((rem_q >= 16'(DOLLAR_VAL)) && avail[2]) begin
                    sel_d   = SEL_DOLLAR;
                    state_d = ST_REQ;
                end else if ((rem_q >= 16'(QUARTER_VAL)) && avail[1]) begin
                    sel_d   = SEL_QUARTER;
                    state_d = ST_REQ;
                end else if ((rem_q >= 16'(DIME_VAL)) && avail[0]) begin
                    sel_d   = SEL_DIME;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_REQ: begin
                // An ack in the abort cycle is still counted before finishing.
                if (coin_ack) begin
                    if (rem_q >= coin_val) rem_d = rem_q - coin_val;
                    coins_d = (coins_q == 8'hFF) ? coins_q : coins_q + 8'd1;
                    sel_d   = SEL_NONE;
                    state_d = ST_SELECT;
                end
                if (abort) begin
                    sel_d   = SEL_NONE;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                sel_d   = SEL_NONE;
                state_d = ST_IDLE;
            end
        endcase
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            done_d     = 1'b1;
            leftover_d = rem_d;
        end
    end

    // State and output registers; req/done/busy come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_NONE;
            rem_q      <= '0;
            coins_q    <= '0;
            leftover_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rem_q      <= rem_d;
            coins_q    <= coins_d;
            leftover_q <= leftover_d;
            done_q     <= done_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign req_dollar  = sel_q[2];
    assign req_quarter = sel_q[1];
    assign req_dime    = sel_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign leftover    = leftover_q;
    assign coins_out   = coins_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser; the inventory scenario runs when
// COIN_INVENTORY_EN is defined for the build.
module tb_coin_change_dispenser;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] change_in;
    logic        abort;
    logic        coin_ack;
    logic        refill;
    logic        req_dollar, req_quarter, req_dime;
    logic        busy, done;
    logic [15:0] leftover;
    logic [7:0]  coins_out;
    logic [2:0]  inv_empty;
    logic        req_any;

    int total = 0;
    int bad   = 0;
    int onehot_bad = 0;

    // results of the last payout
    int          r_done_cyc;
    int          r_nreq;
    int          r_busy1;
    logic [15:0] r_left;
    logic [7:0]  r_coins;
    logic [31:0] r_seq;
    int          r_req_cyc[$];

    coin_change_dispenser dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .change_in   (change_in),
        .abort       (abort),
        .coin_ack    (coin_ack),
        .refill      (refill),
        .req_dollar  (req_dollar),
        .req_quarter (req_quarter),
        .req_dime    (req_dime),
        .busy        (busy),
        .done        (done),
        .leftover    (leftover),
        .coins_out   (coins_out),
        .inv_empty   (inv_empty)
    );

    assign req_any = req_dollar | req_quarter | req_dime;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request one payout and acknowledge each coin 'lat' cycles after its request
    // appears. Coins are logged as 4-bit nibbles {0,D,Q,m}. With 'stray' set, start
    // and coin_ack are pulsed during SELECT cycles, where both must be ignored.
    task automatic pay(input logic [15:0] amt, input int lat, input bit abort_first,
                       input bit stray);
        int  cyc;
        int  held;
        bit  prev;
        r_seq = 0; r_nreq = 0; r_done_cyc = -1; r_busy1 = -1;
        r_left = 16'hDEAD; r_coins = 8'hEE;
        r_req_cyc.delete();
        start = 1'b1; change_in = amt;
        tick();
        start = 1'b0; change_in = 16'h0;
        cyc = 1; prev = 1'b0; held = 0;
        while (cyc < 300 && r_done_cyc < 0) begin
            if (cyc == 1) r_busy1 = int'(busy);
            if ((int'(req_dollar) + int'(req_quarter) + int'(req_dime)) > 1) onehot_bad++;
            if (done) begin
                r_done_cyc = cyc;
                r_left     = leftover;
                r_coins    = coins_out;
            end else if (req_any) begin
                if (!prev) begin
                    r_seq = {r_seq[27:0], 1'b0, req_dollar, req_quarter, req_dime};
                    r_nreq++;
                    r_req_cyc.push_back(cyc);
                    held = 0;
                end
                if (held == lat) begin
                    coin_ack = 1'b1;
                    abort    = abort_first;
                end
                held++;
            end else if (stray && busy) begin
                start = 1'b1; change_in = 16'd999; coin_ack = 1'b1;
            end
            prev = req_any;
            tick();
            coin_ack = 1'b0; abort = 1'b0; start = 1'b0; change_in = 16'h0;
            cyc++;
        end
        if (r_done_cyc < 0) chk("payout_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; change_in = '0; abort = 1'b0;
        coin_ack = 1'b0; refill = 1'b0;
        #1;
        chk("reset_outputs",
            {req_dollar, req_quarter, req_dime, busy, done, leftover, coins_out, inv_empty},
            32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 85c -> Q Q Q D, ack one cycle after each request
        pay(16'd85, 1, 1'b0, 1'b0);
        chk("c85_seq",      r_seq,          32'h2221);
        chk("c85_nreq",     r_nreq,         32'd4);
        chk("c85_coins",    r_coins,        32'd4);
        chk("c85_left",     r_left,         32'd0);
        chk("c85_req1_cyc", r_req_cyc[0],   32'd2);
        chk("c85_req2_cyc", r_req_cyc[1],   32'd5);
        chk("c85_done_cyc", r_done_cyc,     32'd14);
        chk("c85_busy1",    r_busy1,        32'd1);
        chk("c85_busy_off", busy,           32'd0);
        chk("c85_done_off", done,           32'd0);

        // 115c -> dollar, dime; 5c left over
        pay(16'd115, 1, 1'b0, 1'b0);
        chk("c115_seq",      r_seq,      32'h41);
        chk("c115_coins",    r_coins,    32'd2);
        chk("c115_left",     r_left,     32'd5);
        chk("c115_done_cyc", r_done_cyc, 32'd8);
        chk("c115_hold_left", leftover,  32'd5);

        // 0c -> done in N+2, no coins
        pay(16'd0, 1, 1'b0, 1'b0);
        chk("c0_nreq",     r_nreq,     32'd0);
        chk("c0_done_cyc", r_done_cyc, 32'd2);
        chk("c0_left",     r_left,     32'd0);
        chk("c0_coins",    r_coins,    32'd0);

        // 200c, abort together with ack on the first request
        pay(16'd200, 0, 1'b1, 1'b0);
        chk("c200_seq",      r_seq,      32'h4);
        chk("c200_coins",    r_coins,    32'd1);
        chk("c200_left",     r_left,     32'd100);
        chk("c200_done_cyc", r_done_cyc, 32'd3);

        // 35c with stray start/coin_ack during SELECT cycles
        pay(16'd35, 2, 1'b0, 1'b1);
        chk("c35_seq",   r_seq,   32'h21);
        chk("c35_coins", r_coins, 32'd2);
        chk("c35_left",  r_left,  32'd0);

        // coin_ack while idle must not touch coins_out
        coin_ack = 1'b1; tick(); coin_ack = 1'b0; tick();
        chk("idle_ack_coins", coins_out, 32'd2);

        // reset in the middle of a payout, while req_quarter is high
        start = 1'b1; change_in = 16'd75;
        tick();                                   // cycle 1: SELECT
        start = 1'b0;
        tick();                                   // cycle 2: req quarter
        chk("rst_pre_rq", req_quarter, 32'd1);
        coin_ack = 1'b1;
        tick();                                   // cycle 3: SELECT, one coin counted
        coin_ack = 1'b0;
        tick();                                   // cycle 4: req quarter again
        chk("rst_pre_coins", {req_quarter, coins_out}, {24'd0, 1'b1, 8'd1});
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outputs",
            {req_dollar, req_quarter, req_dime, busy, done, leftover, coins_out, inv_empty},
            32'd0);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy || req_any) done_seen++;
            tick();
        end
        chk("rst_quiet", done_seen, 32'd0);

        // recovery from IDLE after reset
        pay(16'd10, 0, 1'b0, 1'b0);
        chk("post_rst_seq",  r_seq,  32'h1);
        chk("post_rst_left", r_left, 32'd0);

`ifdef COIN_INVENTORY_EN
        // drain all 20 quarters with ten 50c payouts
        for (int k = 0; k < 10; k++) pay(16'd50, 0, 1'b0, 1'b0);
        chk("inv_q_empty", inv_empty, 32'b010);
        pay(16'd50, 0, 1'b0, 1'b0);
        chk("inv_dimes_seq",   r_seq,   32'h11111);
        chk("inv_dimes_coins", r_coins, 32'd5);
        chk("inv_dimes_left",  r_left,  32'd0);
        refill = 1'b1; tick(); refill = 1'b0;
        chk("inv_refill", inv_empty, 32'b000);
`else
        // unlimited supply: many dimes later the flags stay clear
        pay(16'd90, 0, 1'b0, 1'b0);
        chk("nolimit_seq", r_seq, 32'h2221);
        chk("nolimit_empty", inv_empty, 32'b000);
`endif

        chk("onehot", onehot_bad, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
